// File: rtl/id_ex_decode_stage_if.sv
// rtl/id_ex_decode_stage_if.sv - IF/ID inputs and ID/EX outputs of the decode stage
interface id_ex_decode_stage_if;
   // Upstream fetch side and pipeline control
   logic        IF_VALID;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC_IN;
   logic        STALL_IN;
   logic        FLUSH;
   logic        LOAD_USE_STALL;

   // Registered ID/EX contents toward the EX stage
   logic        EX_VALID;
   logic [4:0]  ALU_OPCODE;
   logic [31:0] IMM;
   logic [4:0]  RS1_ADDR;
   logic [4:0]  RS2_ADDR;
   logic [4:0]  RD_ADDR;
   logic [31:0] PC_OUT;
   logic        ALU_SRC_IMM;
   logic        ALU_SRC_PC;
   logic        REG_WRITE_EN;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic        BRANCH;
   logic        JUMP;
   logic [2:0]  MEM_FUNCT3;
   logic        ILLEGAL;

   modport master (
      output IF_VALID, INSTRUCTION, PC_IN, STALL_IN, FLUSH,
      input  LOAD_USE_STALL, EX_VALID, ALU_OPCODE, IMM, RS1_ADDR, RS2_ADDR, RD_ADDR,
             PC_OUT, ALU_SRC_IMM, ALU_SRC_PC, REG_WRITE_EN, MEM_READ, MEM_WRITE,
             BRANCH, JUMP, MEM_FUNCT3, ILLEGAL
   );

   modport slave (
      input  IF_VALID, INSTRUCTION, PC_IN, STALL_IN, FLUSH,
      output LOAD_USE_STALL, EX_VALID, ALU_OPCODE, IMM, RS1_ADDR, RS2_ADDR, RD_ADDR,
             PC_OUT, ALU_SRC_IMM, ALU_SRC_PC, REG_WRITE_EN, MEM_READ, MEM_WRITE,
             BRANCH, JUMP, MEM_FUNCT3, ILLEGAL
   );
endinterface

// File: rtl/id_ex_decode_stage.sv
// rtl/id_ex_decode_stage.sv - RV32IM instruction decode and ID/EX pipeline register
module id_ex_decode_stage #(
   parameter int unsigned XLEN       = 32,
   parameter logic [4:0]  NOP_OPCODE = 5'd0
) (
   input logic                 CLK,
   input logic                 RESET,
   id_ex_decode_stage_if.slave bus
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SRL  = 5'd3;
   localparam logic [4:0] ALU_SRA  = 5'd4;
   localparam logic [4:0] ALU_SLT  = 5'd5;
   localparam logic [4:0] ALU_SLTU = 5'd6;
   localparam logic [4:0] ALU_AND  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_XOR  = 5'd9;
   localparam logic [4:0] ALU_MUL  = 5'd10;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   typedef struct packed {
      logic            valid;
      logic [4:0]      alu_op;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic            src_imm;
      logic            src_pc;
      logic            reg_wr;
      logic            mem_rd;
      logic            mem_wr;
      logic            branch;
      logic            jump;
      logic [2:0]      funct3;
      logic            illegal;
   } idex_t;

   idex_t q;
   idex_t dec;
   idex_t cap;
   idex_t bubble;
   logic  legal;
   logic  rs1_used;
   logic  rs2_used;
   logic  load_use;
   logic [4:0] base_op;

   logic [XLEN-1:0] inst;
   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [2:0]      f3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   assign inst   = bus.INSTRUCTION;
   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign f3     = inst[14:12];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign f7     = inst[31:25];

   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_sh = {27'b0, inst[24:20]};

   // Base integer op selected by funct3, shared by OP and OP-IMM
   always_comb begin
      base_op = ALU_ADD;
      case (f3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   end

   // Full instruction decode; legal drops for unknown opcodes or bad field combos
   always_comb begin
      dec        = '0;
      legal      = 1'b1;
      dec.valid  = 1'b1;
      dec.alu_op = ALU_ADD;
      dec.rs1    = rs1;
      dec.rs2    = rs2;
      dec.rd     = rd;
      dec.pc     = bus.PC_IN;
      case (opcode)
         OPC_LUI: begin
            dec.rs1 = '0; dec.imm = imm_u; dec.src_imm = 1'b1; dec.reg_wr = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm = imm_u; dec.src_pc = 1'b1; dec.src_imm = 1'b1; dec.reg_wr = 1'b1;
         end
         OPC_JAL: begin
            dec.imm = imm_j; dec.src_pc = 1'b1; dec.src_imm = 1'b1;
            dec.jump = 1'b1; dec.reg_wr = 1'b1;
         end
         OPC_JALR: begin
            legal = (f3 == 3'b000);
            dec.imm = imm_i; dec.src_imm = 1'b1; dec.jump = 1'b1; dec.reg_wr = 1'b1;
         end
         OPC_BRANCH: begin
            legal = (f3 != 3'b010) && (f3 != 3'b011);
            dec.alu_op = ALU_SUB; dec.imm = imm_b; dec.branch = 1'b1; dec.funct3 = f3;
         end
         OPC_LOAD: begin
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
            dec.imm = imm_i; dec.src_imm = 1'b1; dec.mem_rd = 1'b1;
            dec.reg_wr = 1'b1; dec.funct3 = f3;
         end
         OPC_STORE: begin
            legal = (f3 <= 3'b010);
            dec.imm = imm_s; dec.src_imm = 1'b1; dec.mem_wr = 1'b1; dec.funct3 = f3;
         end
         OPC_OPIMM: begin
            dec.alu_op = base_op; dec.imm = imm_i; dec.src_imm = 1'b1; dec.reg_wr = 1'b1;
            if (f3 == 3'b001) begin
               legal   = (f7 == F7_BASE);
               dec.imm = imm_sh;
            end else if (f3 == 3'b101) begin
               legal   = (f7 == F7_BASE) || (f7 == F7_ALT);
               dec.imm = imm_sh;
               if (f7 == F7_ALT) dec.alu_op = ALU_SRA;
            end
         end
         OPC_OP: begin
            dec.reg_wr = 1'b1;
            if (f7 == F7_BASE) begin
               dec.alu_op = base_op;
            end else if (f7 == F7_ALT) begin
               legal      = (f3 == 3'b000) || (f3 == 3'b101);
               dec.alu_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
            end else if (f7 == F7_MUL) begin
               dec.alu_op = ALU_MUL + {2'b00, f3};
            end else begin
               legal = 1'b0;
            end
         end
         default: legal = 1'b0;
      endcase
      if (rd == 5'd0) dec.reg_wr = 1'b0;
   end

   // Bubble pattern: nothing valid, ALU idles on the NOP opcode
   always_comb begin
      bubble        = '0;
      bubble.alu_op = NOP_OPCODE;
   end

   // Value written on a capture: decoded fields, or a bubble flagged illegal
   always_comb begin
      cap = bubble;
      if (legal) cap = dec;
      else       cap.illegal = 1'b1;
   end

   // Load in EX whose destination is a source of the instruction now in ID
   always_comb begin
      rs1_used = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
      rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
      load_use = bus.IF_VALID && q.valid && q.mem_rd && (q.rd != 5'd0) &&
                 ((rs1_used && (rs1 == q.rd)) || (rs2_used && (rs2 == q.rd)));
   end

   // ID/EX register: flush beats stall, stall holds, hazard or idle inserts a bubble
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         q <= bubble;
      end else if (bus.FLUSH) begin
         q <= bubble;
      end else if (!bus.STALL_IN) begin
         if (load_use)          q <= bubble;
         else if (bus.IF_VALID) q <= cap;
         else                   q <= bubble;
      end
   end

   assign bus.LOAD_USE_STALL = load_use;
   assign bus.EX_VALID       = q.valid;
   assign bus.ALU_OPCODE     = q.alu_op;
   assign bus.IMM            = q.imm;
   assign bus.RS1_ADDR       = q.rs1;
   assign bus.RS2_ADDR       = q.rs2;
   assign bus.RD_ADDR        = q.rd;
   assign bus.PC_OUT         = q.pc;
   assign bus.ALU_SRC_IMM    = q.src_imm;
   assign bus.ALU_SRC_PC     = q.src_pc;
   assign bus.REG_WRITE_EN   = q.reg_wr;
   assign bus.MEM_READ       = q.mem_rd;
   assign bus.MEM_WRITE      = q.mem_wr;
   assign bus.BRANCH         = q.branch;
   assign bus.JUMP           = q.jump;
   assign bus.MEM_FUNCT3     = q.funct3;
   assign bus.ILLEGAL        = q.illegal;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// tb/tb_id_ex_decode_stage.sv - directed and randomized checks of id_ex_decode_stage
module tb_id_ex_decode_stage;

   typedef struct packed {
      logic        ex_valid;
      logic [4:0]  alu;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        src_imm;
      logic        src_pc;
      logic        wr;
      logic        mrd;
      logic        mwr;
      logic        br;
      logic        jmp;
      logic [2:0]  f3;
      logic        illegal;
   } out_t;

   typedef struct packed {
      logic [31:0] mask;
      logic [31:0] match;
      logic [4:0]  alu;
      logic [2:0]  fmt;
      logic [8:0]  flags;
   } ent_t;

   localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_SH = 3'd6;

   localparam logic [8:0] F_IMM = 9'h100, F_PC = 9'h080, F_WR = 9'h040, F_MRD = 9'h020;
   localparam logic [8:0] F_MWR = 9'h010, F_BR = 9'h008, F_JMP = 9'h004, F_F3 = 9'h002;
   localparam logic [8:0] F_LUI = 9'h001;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   ent_t tbl[$];
   out_t exp_q;
   int   base_alu [8] = '{0, 2, 5, 6, 9, 3, 8, 7};

   always #5 clk = ~clk;

   id_ex_decode_stage_if bus ();

   id_ex_decode_stage #(.XLEN(32), .NOP_OPCODE(5'd0)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   // Instruction set as mask/match patterns, one row per legal encoding family
   function automatic void build_table();
      logic [31:0] f3s;
      for (int f = 0; f < 8; f++) begin
         f3s = 32'(f) << 12;
         if (f != 2 && f != 3)
            tbl.push_back({32'h0000707F, 32'h63 | f3s, 5'd1, FMT_B, F_BR | F_F3});
         if (f < 3 || f == 4 || f == 5)
            tbl.push_back({32'h0000707F, 32'h03 | f3s, 5'd0, FMT_I, F_IMM | F_WR | F_MRD | F_F3});
         if (f < 3)
            tbl.push_back({32'h0000707F, 32'h23 | f3s, 5'd0, FMT_S, F_IMM | F_MWR | F_F3});
         if (f != 1 && f != 5)
            tbl.push_back({32'h0000707F, 32'h13 | f3s, 5'(base_alu[f]), FMT_I, F_IMM | F_WR});
         tbl.push_back({32'hFE00707F, 32'h33 | f3s, 5'(base_alu[f]), FMT_R, F_WR});
         tbl.push_back({32'hFE00707F, 32'h02000033 | f3s, 5'(10 + f), FMT_R, F_WR});
      end
      tbl.push_back({32'h0000007F, 32'h00000037, 5'd0, FMT_U, F_IMM | F_WR | F_LUI});
      tbl.push_back({32'h0000007F, 32'h00000017, 5'd0, FMT_U, F_IMM | F_PC | F_WR});
      tbl.push_back({32'h0000007F, 32'h0000006F, 5'd0, FMT_J, F_IMM | F_PC | F_WR | F_JMP});
      tbl.push_back({32'h0000707F, 32'h00000067, 5'd0, FMT_I, F_IMM | F_WR | F_JMP});
      tbl.push_back({32'hFE00707F, 32'h00001013, 5'd2, FMT_SH, F_IMM | F_WR});
      tbl.push_back({32'hFE00707F, 32'h00005013, 5'd3, FMT_SH, F_IMM | F_WR});
      tbl.push_back({32'hFE00707F, 32'h40005013, 5'd4, FMT_SH, F_IMM | F_WR});
      tbl.push_back({32'hFE00707F, 32'h40000033, 5'd1, FMT_R, F_WR});
      tbl.push_back({32'hFE00707F, 32'h40005033, 5'd4, FMT_R, F_WR});
   endfunction

   function automatic out_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      out_t o;
      ent_t e;
      int   hit;
      o   = '0;
      hit = -1;
      foreach (tbl[k]) if ((ins & tbl[k].mask) == tbl[k].match) hit = k;
      if (hit < 0) begin
         o.illegal = 1'b1;
         return o;
      end
      e          = tbl[hit];
      o.ex_valid = 1'b1;
      o.alu      = e.alu;
      o.pc       = pc;
      o.rd       = ins[11:7];
      o.rs1      = ((e.flags & F_LUI) != 0) ? 5'd0 : ins[19:15];
      o.rs2      = ins[24:20];
      case (e.fmt)
         FMT_I:   o.imm = 32'($signed(ins) >>> 20);
         FMT_S:   o.imm = (32'($signed(ins) >>> 20) & ~32'h1F) | (ins >> 7 & 32'h1F);
         FMT_B:   o.imm = (32'($signed(ins) >>> 19) & 32'hFFFFF000) | (32'(ins[7]) << 11) |
                          (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
         FMT_U:   o.imm = ins & 32'hFFFFF000;
         FMT_J:   o.imm = (32'($signed(ins) >>> 11) & 32'hFFF00000) | (ins & 32'h000FF000) |
                          (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
         FMT_SH:  o.imm = 32'(ins[24:20]);
         default: o.imm = '0;
      endcase
      o.src_imm = (e.flags & F_IMM) != 0;
      o.src_pc  = (e.flags & F_PC) != 0;
      o.wr      = ((e.flags & F_WR) != 0) && (ins[11:7] != 5'd0);
      o.mrd     = (e.flags & F_MRD) != 0;
      o.mwr     = (e.flags & F_MWR) != 0;
      o.br      = (e.flags & F_BR) != 0;
      o.jmp     = (e.flags & F_JMP) != 0;
      o.f3      = ((e.flags & F_F3) != 0) ? ins[14:12] : 3'd0;
      return o;
   endfunction

   function automatic logic ref_hazard(input out_t ex, input logic v, input logic [31:0] ins);
      logic uses1, uses2;
      uses1 = !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6F);
      uses2 = (ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63);
      return v && ex.ex_valid && ex.mrd && (ex.rd != 5'd0) &&
             ((uses1 && ins[19:15] == ex.rd) || (uses2 && ins[24:20] == ex.rd));
   endfunction

   function automatic out_t ref_next(input out_t cur, input logic r, input logic fl, input logic st,
                                     input logic hz, input logic v, input logic [31:0] ins,
                                     input logic [31:0] pc);
      if (!r || fl) return '0;
      if (st)       return cur;
      if (hz || !v) return '0;
      return ref_decode(ins, pc);
   endfunction

   function automatic out_t actual();
      return {bus.EX_VALID, bus.ALU_OPCODE, bus.IMM, bus.RS1_ADDR, bus.RS2_ADDR, bus.RD_ADDR,
              bus.PC_OUT, bus.ALU_SRC_IMM, bus.ALU_SRC_PC, bus.REG_WRITE_EN, bus.MEM_READ,
              bus.MEM_WRITE, bus.BRANCH, bus.JUMP, bus.MEM_FUNCT3, bus.ILLEGAL};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int k;
      r = $urandom;
      if ($urandom_range(0, 9) < 8) begin
         k = $urandom_range(0, tbl.size() - 1);
         r = (r & ~tbl[k].mask) | tbl[k].match;
      end
      if ($urandom_range(0, 1) == 1) begin
         r[11:7]  = 5'($urandom_range(0, 3));
         r[19:15] = 5'($urandom_range(0, 3));
         r[24:20] = 5'($urandom_range(0, 3));
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl);
      bus.IF_VALID    = v;
      bus.INSTRUCTION = ins;
      bus.PC_IN       = pc;
      bus.STALL_IN    = st;
      bus.FLUSH       = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b0);
      tick();
      tick();
      total_cnt++;
      if (actual() !== out_t'('0)) $display("FAIL reset_state got=%h exp=%h", actual(), out_t'('0));
      else pass_cnt++;
      total_cnt++;
      if (bus.LOAD_USE_STALL !== 1'b0) $display("FAIL reset_lus got=%b exp=0", bus.LOAD_USE_STALL);
      else pass_cnt++;
   endtask

   task automatic test_add_sub();
      out_t e;
      rst = 1'b1;
      drive(1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b0);
      #1;
      total_cnt++;
      if (bus.EX_VALID !== 1'b0) $display("FAIL add_latency got=%b exp=0", bus.EX_VALID);
      else pass_cnt++;
      tick();
      e = '0; e.ex_valid = 1'b1; e.alu = 5'd0; e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd3;
      e.pc = 32'h100; e.wr = 1'b1;
      total_cnt++;
      if (actual() !== e) $display("FAIL add got=%h exp=%h", actual(), e);
      else pass_cnt++;
      drive(1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b0);
      tick();
      e.alu = 5'd1; e.pc = 32'h104;
      total_cnt++;
      if (actual() !== e) $display("FAIL sub got=%h exp=%h", actual(), e);
      else pass_cnt++;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (bus.EX_VALID !== 1'b0) $display("FAIL idle_bubble got=%b exp=0", bus.EX_VALID);
      else pass_cnt++;
   endtask

   task automatic test_mul_addi();
      out_t e;
      drive(1'b1, 32'h027302B3, 32'h200, 1'b0, 1'b0);
      tick();
      e = '0; e.ex_valid = 1'b1; e.alu = 5'd10; e.rs1 = 5'd6; e.rs2 = 5'd7; e.rd = 5'd5;
      e.pc = 32'h200; e.wr = 1'b1;
      total_cnt++;
      if (actual() !== e) $display("FAIL mul got=%h exp=%h", actual(), e);
      else pass_cnt++;
      drive(1'b1, 32'hFFF00093, 32'h204, 1'b0, 1'b0);
      tick();
      e = '0; e.ex_valid = 1'b1; e.alu = 5'd0; e.imm = 32'hFFFFFFFF; e.rs1 = 5'd0;
      e.rs2 = 5'd31; e.rd = 5'd1; e.pc = 32'h204; e.src_imm = 1'b1; e.wr = 1'b1;
      total_cnt++;
      if (actual() !== e) $display("FAIL addi got=%h exp=%h", actual(), e);
      else pass_cnt++;
   endtask

   task automatic test_load_use();
      out_t e;
      drive(1'b1, 32'h0000A203, 32'h300, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h004202B3, 32'h304, 1'b0, 1'b0);
      #1;
      total_cnt++;
      if (bus.LOAD_USE_STALL !== 1'b1) $display("FAIL lus_raised got=%b exp=1", bus.LOAD_USE_STALL);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (actual() !== out_t'('0)) $display("FAIL lus_bubble got=%h exp=%h", actual(), out_t'('0));
      else pass_cnt++;
      total_cnt++;
      if (bus.LOAD_USE_STALL !== 1'b0) $display("FAIL lus_cleared got=%b exp=0", bus.LOAD_USE_STALL);
      else pass_cnt++;
      tick();
      e = '0; e.ex_valid = 1'b1; e.alu = 5'd0; e.rs1 = 5'd4; e.rs2 = 5'd4; e.rd = 5'd5;
      e.pc = 32'h304; e.wr = 1'b1;
      total_cnt++;
      if (actual() !== e) $display("FAIL lus_replay got=%h exp=%h", actual(), e);
      else pass_cnt++;
   endtask

   task automatic test_stall_flush();
      out_t e;
      drive(1'b1, 32'h002081B3, 32'h400, 1'b0, 1'b0);
      tick();
      e = '0; e.ex_valid = 1'b1; e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd3;
      e.pc = 32'h400; e.wr = 1'b1;
      drive(1'b1, 32'h402081B3, 32'h404, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if (actual() !== e) $display("FAIL stall_hold%0d got=%h exp=%h", i, actual(), e);
         else pass_cnt++;
      end
      drive(1'b1, 32'h402081B3, 32'h404, 1'b1, 1'b1);
      tick();
      total_cnt++;
      if (bus.EX_VALID !== 1'b0) $display("FAIL flush_over_stall got=%b exp=0", bus.EX_VALID);
      else pass_cnt++;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_illegal();
      out_t e;
      e = '0; e.illegal = 1'b1;
      drive(1'b1, 32'hFFFFFFFF, 32'h500, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (actual() !== e) $display("FAIL illegal_ones got=%h exp=%h", actual(), e);
      else pass_cnt++;
      drive(1'b1, 32'h4020F1B3, 32'h504, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (actual() !== e) $display("FAIL illegal_f7 got=%h exp=%h", actual(), e);
      else pass_cnt++;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (bus.ILLEGAL !== 1'b0) $display("FAIL illegal_clear got=%b exp=0", bus.ILLEGAL);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic v, st, fl, r, hz;
      logic [31:0] ins, pc;
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      exp_q = '0;
      for (int n = 0; n < 400; n++) begin
         v   = ($urandom_range(0, 9) < 8);
         st  = ($urandom_range(0, 9) < 2);
         fl  = ($urandom_range(0, 9) < 1);
         r   = ($urandom_range(0, 49) != 0);
         ins = rand_instr();
         pc  = $urandom & ~32'h3;
         rst = r;
         drive(v, ins, pc, st, fl);
         #1;
         hz = ref_hazard(exp_q, v, ins);
         total_cnt++;
         if (bus.LOAD_USE_STALL !== hz)
            $display("FAIL rand_lus[%0d] got=%b exp=%b ins=%h", n, bus.LOAD_USE_STALL, hz, ins);
         else pass_cnt++;
         exp_q = ref_next(exp_q, r, fl, st, hz, v, ins, pc);
         tick();
         total_cnt++;
         if (actual() !== exp_q)
            $display("FAIL rand_state[%0d] got=%h exp=%h ins=%h", n, actual(), exp_q, ins);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      build_table();
      @(posedge clk);
      #1;
      test_reset();
      test_add_sub();
      test_mul_addi();
      test_load_use();
      test_stall_flush();
      test_illegal();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/id_ex_decode_stage.md
Name: id_ex_decode_stage

Overview:
- Instruction-decode stage and ID/EX pipeline register for the RV32IM pipeline.
- Decodes 32-bit instructions into the 5-bit ALU opcode consumed by the EX-stage ALU, plus the immediate, register addresses and control bits.
- Registers all decoded fields toward EX, with stall, flush and load-use hazard bubble insertion.

Parameters:
- XLEN, 32, datapath/instruction width (fixed at 32; not for override)
- NOP_OPCODE, 5'd0, ALU opcode driven during bubbles and reset (ADD)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-low reset
- IF_VALID  input  1  INSTRUCTION/PC_IN hold a valid fetched instruction
- INSTRUCTION  input  32  instruction word from IF/ID
- PC_IN  input  32  PC of INSTRUCTION
- STALL_IN  input  1  downstream stall; hold ID/EX contents
- FLUSH  input  1  branch/jump redirect; kill the instruction being captured
- LOAD_USE_STALL  output  1  combinational; upstream must hold IF/ID this cycle
- EX_VALID  output  1  registered; EX-stage contents valid
- ALU_OPCODE  output  5  registered ALU operation
- IMM  output  32  registered sign-extended immediate
- RS1_ADDR, RS2_ADDR, RD_ADDR  output  5 each  registered register addresses
- PC_OUT  output  32  registered PC
- ALU_SRC_IMM  output  1  operand 2 = IMM
- ALU_SRC_PC  output  1  operand 1 = PC
- REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP  output  1 each  control bits
- MEM_FUNCT3  output  3  funct3 for load/store/branch
- ILLEGAL  output  1  registered; captured instruction was undecodable

Behaviour:
- ALU opcode encoding: ADD 0, SUB 1, SLL 2, SRL 3, SRA 4, SLT 5, SLTU 6, AND 7, OR 8, XOR 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
- Reset (RESET=0 at edge): every registered output is 0; ALU_OPCODE = NOP_OPCODE.
- Update priority at each edge:
  - FLUSH: bubble.
  - Else STALL_IN: hold all registers.
  - Else LOAD_USE_STALL: bubble.
  - Else IF_VALID: capture decoded fields.
  - Else: bubble.
- Bubble: EX_VALID, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP and ILLEGAL = 0; ALU_OPCODE = NOP_OPCODE; other fields don't-care (driven 0).
- LOAD_USE_STALL = IF_VALID & EX_VALID & MEM_READ & RD_ADDR!=0 & ((rs1 used & rs1==RD_ADDR) | (rs2 used & rs2==RD_ADDR)).
  - rs2 is used only by OP, store and branch.
  - rs1 is used by all formats except LUI, AUIPC and JAL.
- Latency: one cycle from IF_VALID capture to EX_VALID.
- Decode by opcode[6:0]; a valid capture sets EX_VALID=1:
  - LUI 0110111: ADD; RS1_ADDR forced 0; U-imm; ALU_SRC_IMM; REG_WRITE_EN.
  - AUIPC 0010111: ADD; U-imm; ALU_SRC_PC; ALU_SRC_IMM; REG_WRITE_EN.
  - JAL 1101111: ADD; J-imm; ALU_SRC_PC; ALU_SRC_IMM; JUMP; REG_WRITE_EN.
  - JALR 1100111: funct3 must be 000. ADD; I-imm; ALU_SRC_IMM; JUMP; REG_WRITE_EN.
  - BRANCH 1100011: funct3 010/011 illegal. SUB; B-imm; BRANCH; MEM_FUNCT3=funct3.
  - LOAD 0000011: funct3 in {000,001,010,100,101}. ADD; I-imm; MEM_READ; REG_WRITE_EN.
  - STORE 0100011: funct3 in {000,001,010}. ADD; S-imm; MEM_WRITE.
  - OP-IMM 0010011: funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL-or-SRA/OR/AND.
    - Shifts: imm[11:5] must be 0000000, except SRAI = 0100000; otherwise illegal.
    - SRAI/SRLI IMM = shamt zero-extended.
  - OP 0110011: funct7 0000000 gives base ops; 0100000 is legal only with funct3 000 (SUB) or 101 (SRA); 0000001 with funct3 000..111 gives MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Any other opcode or illegal field combination: capture as bubble but ILLEGAL=1 for that cycle.
- rd=x0: REG_WRITE_EN forced 0.
- Immediates are sign-extended from bit 31; B/J bit 0 = 0; U-imm = {inst[31:12], 12'b0}.
- Simultaneous FLUSH and LOAD_USE_STALL: flush wins. LOAD_USE_STALL output still reflects hazard logic; upstream applies its own flush priority.
- Reset mid-stall or mid-hazard clears all state; LOAD_USE_STALL goes 0 the next cycle because EX_VALID=0.

Test Plan:
- Reset held low for 2 cycles with IF_VALID=1 -> all outputs 0, ALU_OPCODE=0, EX_VALID=0.
- 0x002081B3 (add x3,x1,x2), then 0x402081B3 (sub) -> ALU_OPCODE 0 then 1; RD=3, RS1=1, RS2=2; REG_WRITE_EN=1, one-cycle latency.
- 0x027302B3 (mul x5,x6,x7) -> ALU_OPCODE=10, RD=5; 0xFFF00093 (addi x1,x0,-1) -> ALU_OPCODE=0, IMM=0xFFFFFFFF, ALU_SRC_IMM=1.
- 0x0000A203 (lw x4,0(x1)) followed by 0x004202B3 (add x5,x4,x4) -> LOAD_USE_STALL=1 for one cycle, one bubble, then add captured with EX_VALID=1.
- STALL_IN=1 for 3 cycles during a valid add -> all outputs frozen; FLUSH=1 with STALL_IN=1 -> EX_VALID=0 next cycle.
- 0xFFFFFFFF and 0x4020F1B3 (funct7=0100000 with funct3=111) -> ILLEGAL=1, EX_VALID=0, REG_WRITE_EN=0.
